// File: rtl/axis_frame_stat.sv
// Purpose: small synchronous first-word-fall-through FIFO. The head reads as zero while empty.
// Latency: a pushed word is visible at the output on the cycle after the write.
// Backpressure: in_rdy is low only when the FIFO is full and the head is not being popped.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_vld = !empty;
    // A full FIFO always has a valid head, so a pop in the same cycle frees a slot.
    assign in_rdy  = !full || out_rdy;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;
    assign out_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

// Purpose: passive AXI-Stream frame monitor. It counts bytes per frame and queues one length/flag record per frame.
// Latency: a record appears on status_* on the cycle after the tlast beat when the queue is empty.
// Backpressure: status_ready stalls the record queue. A record that arrives while the queue is full is dropped and counted.
module axis_frame_stat #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int LEN_WIDTH   = 16,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic                  monitor_axis_tvalid,
    input  logic                  monitor_axis_tready,
    input  logic                  monitor_axis_tlast,
    input  logic                  monitor_axis_tuser,
    output logic [LEN_WIDTH-1:0]  status_len,
    output logic                  status_runt,
    output logic                  status_oversize,
    output logic                  status_err,
    output logic                  status_sat,
    output logic                  status_valid,
    input  logic                  status_ready,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);
    localparam int CW = $clog2(KEEP_WIDTH + 1);
    localparam int SW = LEN_WIDTH + 1;
    localparam logic [31:0] MIN_U = 32'(MIN_LEN);
    localparam logic [31:0] MAX_U = 32'(MAX_LEN);

    typedef struct packed {
        logic [LEN_WIDTH-1:0] len;
        logic                 runt;
        logic                 oversize;
        logic                 err;
        logic                 sat;
    } rec_t;

    logic [LEN_WIDTH-1:0] len_acc;
    logic                 err_acc;
    logic                 sat_acc;
    logic [CW-1:0]        beat_bytes;
    logic [SW-1:0]        sum;
    logic                 ovf;
    logic [LEN_WIDTH-1:0] new_len;
    logic [31:0]          len_ext;
    logic                 accept;
    logic                 rec_vld;
    logic                 fifo_in_rdy;
    rec_t                 rec_in;
    rec_t                 rec_out;

    assign accept = monitor_axis_tvalid && monitor_axis_tready;

    always_comb begin
        beat_bytes = '0;
        if (KEEP_ENABLE != 0) begin
            for (int i = 0; i < KEEP_WIDTH; i++)
                beat_bytes = beat_bytes + CW'(monitor_axis_tkeep[i]);
        end else begin
            beat_bytes = CW'(KEEP_WIDTH);
        end
    end

    // One extra bit catches the wrap; once clamped, further beats keep the length at all-ones.
    assign sum     = {1'b0, len_acc} + SW'(beat_bytes);
    assign ovf     = sum[LEN_WIDTH];
    assign new_len = ovf ? '1 : sum[LEN_WIDTH-1:0];
    assign len_ext = 32'(new_len);

    assign rec_vld         = accept && monitor_axis_tlast;
    assign rec_in.len      = new_len;
    assign rec_in.runt     = (len_ext < MIN_U);
    assign rec_in.oversize = (len_ext > MAX_U);
    assign rec_in.err      = err_acc || monitor_axis_tuser;
    assign rec_in.sat      = sat_acc || ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_acc <= '0;
            err_acc <= 1'b0;
            sat_acc <= 1'b0;
        end else if (accept) begin
            if (monitor_axis_tlast) begin
                len_acc <= '0;
                err_acc <= 1'b0;
                sat_acc <= 1'b0;
            end else begin
                len_acc <= new_len;
                err_acc <= rec_in.err;
                sat_acc <= rec_in.sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else if (rec_vld) begin
            frame_count <= frame_count + 1'b1;
            if (!fifo_in_rdy) drop_count <= drop_count + 1'b1;
        end
    end

    sync_fifo #(
        .W     ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rec_vld),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (rec_in),
        .out_vld (status_valid),
        .out_rdy (status_ready),
        .out_dat (rec_out)
    );

    assign status_len      = rec_out.len;
    assign status_runt     = rec_out.runt;
    assign status_oversize = rec_out.oversize;
    assign status_err      = rec_out.err;
    assign status_sat      = rec_out.sat;
endmodule

// File: tb/tb_axis_frame_stat.sv
// Testbench for axis_frame_stat. It uses a default 64-bit instance and an 8-bit-length instance with tkeep ignored.
// Expected records are queued when frames are driven, and negedge monitors compare each popped record.
module tb_axis_frame_stat;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  m_keep = '0;
    logic        m_valid = 1'b0, m_ready = 1'b1, m_last = 1'b0, m_user = 1'b0;
    logic [15:0] s_len;
    logic        s_runt, s_ov, s_err, s_sat, s_valid;
    logic        s_ready = 1'b1;
    logic [31:0] f_cnt, d_cnt;

    logic [7:0]  m2_keep = '0;
    logic        m2_valid = 1'b0, m2_ready = 1'b1, m2_last = 1'b0, m2_user = 1'b0;
    logic [7:0]  s2_len;
    logic        s2_runt, s2_ov, s2_err, s2_sat, s2_valid;
    logic        s2_ready = 1'b1;
    logic [31:0] f2_cnt, d2_cnt;

    int errors = 0;
    int checks = 0;
    logic [19:0] q1 [$];
    logic [19:0] q2 [$];

    always #5 clk = ~clk;

    axis_frame_stat dut (
        .clk(clk), .rst(rst),
        .monitor_axis_tkeep(m_keep), .monitor_axis_tvalid(m_valid),
        .monitor_axis_tready(m_ready), .monitor_axis_tlast(m_last),
        .monitor_axis_tuser(m_user),
        .status_len(s_len), .status_runt(s_runt), .status_oversize(s_ov),
        .status_err(s_err), .status_sat(s_sat),
        .status_valid(s_valid), .status_ready(s_ready),
        .frame_count(f_cnt), .drop_count(d_cnt)
    );

    axis_frame_stat #(
        .KEEP_ENABLE(0), .LEN_WIDTH(8), .MAX_LEN(200)
    ) dut2 (
        .clk(clk), .rst(rst),
        .monitor_axis_tkeep(m2_keep), .monitor_axis_tvalid(m2_valid),
        .monitor_axis_tready(m2_ready), .monitor_axis_tlast(m2_last),
        .monitor_axis_tuser(m2_user),
        .status_len(s2_len), .status_runt(s2_runt), .status_oversize(s2_ov),
        .status_err(s2_err), .status_sat(s2_sat),
        .status_valid(s2_valid), .status_ready(s2_ready),
        .frame_count(f2_cnt), .drop_count(d2_cnt)
    );

    function automatic logic [19:0] rec(input int len, input bit r, o, e, s);
        return {16'(len), r, o, e, s};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Records are popped on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && s_valid && s_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rec1 unexpected: got %0h expected none", {s_len, s_runt, s_ov, s_err, s_sat});
            end else begin
                logic [19:0] e;
                e = q1.pop_front();
                if ({s_len, s_runt, s_ov, s_err, s_sat} !== e) begin
                    errors++;
                    $display("FAIL rec1: got %0h expected %0h", {s_len, s_runt, s_ov, s_err, s_sat}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s2_valid && s2_ready) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL rec2 unexpected: got %0h expected none", {8'h0, s2_len, s2_runt, s2_ov, s2_err, s2_sat});
            end else begin
                logic [19:0] e;
                e = q2.pop_front();
                if ({8'h0, s2_len, s2_runt, s2_ov, s2_err, s2_sat} !== e) begin
                    errors++;
                    $display("FAIL rec2: got %0h expected %0h", {8'h0, s2_len, s2_runt, s2_ov, s2_err, s2_sat}, e);
                end
            end
        end
    end

    task automatic beat(input logic [7:0] k, input logic l, input logic u, input logic r = 1'b1);
        m_keep = k; m_last = l; m_user = u; m_valid = 1'b1; m_ready = r;
        @(posedge clk); #1;
        m_valid = 1'b0; m_last = 1'b0; m_user = 1'b0; m_ready = 1'b1;
    endtask

    task automatic beat2(input logic [7:0] k, input logic l);
        m2_keep = k; m2_last = l; m2_valid = 1'b1;
        @(posedge clk); #1;
        m2_valid = 1'b0; m2_last = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && q2.size() == 0 && !s_valid && !s2_valid) break;
            @(posedge clk); #1;
        end
        chk(name, 64'(q1.size() + q2.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(s_valid), 64'd0);
        chk("rst_len", 64'(s_len), 64'd0);
        chk("rst_flags", 64'({s_runt, s_ov, s_err, s_sat}), 64'd0);
        chk("rst_frames", 64'(f_cnt), 64'd0);
        chk("rst_drops", 64'(d_cnt), 64'd0);
        chk("rst_valid2", 64'(s2_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // The 0x0F tail makes a 20-byte runt. The stalled beat must not be counted.
        q1.push_back(rec(20, 1, 0, 0, 0));
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b1, 1'b0);
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'h0F, 1'b1, 1'b0);
        chk("valid_after_last", 64'(s_valid), 64'd1);

        // These frames are back to back. They cover non-contiguous tkeep, tkeep of zero and sticky tuser.
        q1.push_back(rec(4, 1, 0, 1, 0));
        beat(8'hA5, 1'b1, 1'b1);
        q1.push_back(rec(8, 1, 0, 0, 0));
        beat(8'hFF, 1'b1, 1'b0);
        q1.push_back(rec(16, 1, 0, 1, 0));
        beat(8'hFF, 1'b0, 1'b1);
        beat(8'hFF, 1'b1, 1'b0);
        q1.push_back(rec(8, 1, 0, 0, 0));
        beat(8'h00, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0);
        drain("drain_a");
        chk("frames_a", 64'(f_cnt), 64'd5);
        chk("drops_a", 64'(d_cnt), 64'd0);

        // With the status side stalled, 6 frames of 64 bytes are sent. Only 4 records fit.
        s_ready = 1'b0;
        for (int f = 0; f < 6; f++) begin
            if (f < 4) q1.push_back(rec(64, 0, 0, 0, 0));
            for (int b = 0; b < 8; b++) beat(8'hFF, b == 7, 1'b0);
        end
        chk("frames_full", 64'(f_cnt), 64'd11);
        chk("drops_full", 64'(d_cnt), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_valid", 64'(s_valid), 64'd1);
        chk("hold_len", 64'(s_len), 64'd64);

        // The FIFO is full. A pop and a push in the same cycle must not drop the new record.
        q1.push_back(rec(8, 1, 0, 0, 0));
        s_ready = 1'b1;
        beat(8'hFF, 1'b1, 1'b0);
        chk("drops_pushpop", 64'(d_cnt), 64'd2);
        chk("frames_pushpop", 64'(f_cnt), 64'd12);
        drain("drain_b");

        // A reset in the middle of a frame discards the partial frame and any beat seen during reset.
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        beat(8'hFF, 1'b1, 1'b0);
        rst = 1'b0;
        chk("rst2_frames", 64'(f_cnt), 64'd0);
        chk("rst2_drops", 64'(d_cnt), 64'd0);
        chk("rst2_valid", 64'(s_valid), 64'd0);
        q1.push_back(rec(16, 1, 0, 0, 0));
        beat(8'hFF, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0);
        drain("drain_c");
        chk("frames_c", 64'(f_cnt), 64'd1);

        // The 8-bit length instance ignores tkeep. 40 beats of 8 bytes saturate the length at 255.
        q2.push_back(rec(255, 0, 1, 0, 1));
        for (int b = 0; b < 40; b++) beat2(8'h00, b == 39);
        q2.push_back(rec(16, 1, 0, 0, 0));
        beat2(8'h00, 1'b0);
        beat2(8'h00, 1'b1);
        drain("drain_d");
        chk("frames2", 64'(f2_cnt), 64'd2);
        chk("drops2", 64'(d2_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_frame_stat.md
AXIS_FRAME_STAT -- requirements
Module: axis_frame_stat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: monitored stream data width in bits.
REQ-002 SHALL have parameter KEEP_ENABLE, default (DATA_WIDTH>8): use tkeep; when 0, every beat is full.
REQ-003 SHALL have parameter KEEP_WIDTH, default ((DATA_WIDTH+7)/8): tkeep width in bytes per beat.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: frame byte-length width.
REQ-005 SHALL have parameter MIN_LEN, default 64: runt threshold in bytes.
REQ-006 SHALL have parameter MAX_LEN, default 1518: oversize threshold in bytes.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2: status record FIFO depth.
REQ-008 SHALL have parameter CNT_WIDTH, default 32: frame and drop counter width.
REQ-009 clk  input  1  clock; all logic on rising edge.
REQ-010 rst  input  1  synchronous, active-high reset.
REQ-011 monitor_axis_tkeep  input  KEEP_WIDTH  byte qualifiers of the monitored beat.
REQ-012 monitor_axis_tvalid / monitor_axis_tready / monitor_axis_tlast / monitor_axis_tuser  input  1 each  monitored handshake, end-of-frame flag and per-beat error flag.
REQ-013 status_len  output  LEN_WIDTH  frame length in bytes.
REQ-014 status_runt / status_oversize / status_err / status_sat  output  1 each  record flags.
REQ-015 status_valid  output 1; status_ready  input 1  status record handshake.
REQ-016 frame_count / drop_count  output  CNT_WIDTH  completed frames / records dropped on FIFO full.

Function
REQ-017 SHALL treat a beat as accepted only when tvalid and tready are both 1; other cycles change no frame state.
REQ-018 SHALL add popcount(tkeep) per accepted beat when KEEP_ENABLE=1; non-contiguous tkeep counts every set bit; tkeep=0 adds 0.
REQ-019 SHALL add KEEP_WIDTH per accepted beat when KEEP_ENABLE=0.
REQ-020 SHALL saturate the accumulator at 2^LEN_WIDTH-1 and set a sticky sat flag for the frame.
REQ-021 SHALL OR tuser across all accepted beats of the frame into a sticky err flag.
REQ-022 On an accepted tlast beat, SHALL form a record including that beat: len=final total, runt=(len<MIN_LEN), oversize=(len>MAX_LEN), err, sat.
REQ-023 SHALL clear accumulator, err and sat in the same cycle, so the next accepted beat starts a new frame with no gap.
REQ-024 SHALL push the record into the FIFO when not full, or when full with a pop in the same cycle.
REQ-025 Otherwise SHALL discard the record and increment drop_count.
REQ-026 SHALL increment frame_count on every accepted tlast, whether or not the record is dropped.
REQ-027 frame_count and drop_count SHALL wrap modulo 2^CNT_WIDTH.
REQ-028 SHALL present the FIFO head on status_* as first-word-fall-through.
REQ-029 status_valid SHALL assert the cycle after the tlast beat when the FIFO was empty.
REQ-030 SHALL pop on status_valid and status_ready both 1.
REQ-031 status_* SHALL hold stable while status_valid=1 and status_ready=0.
REQ-032 SHALL sustain one tlast per cycle (single-beat frames) with one record per frame.
REQ-033 Status outputs SHALL be undefined-free: when empty, status_len=0 and all status flags are 0.

Reset
REQ-034 On rst, SHALL clear accumulator, err, sat, FIFO pointers, frame_count and drop_count.
REQ-035 On rst, SHALL drive status_valid=0, status_len=0 and all status flags to 0 on the next cycle.
REQ-036 SHALL discard a partial frame in progress at reset; beats accepted while rst=1 are ignored.

Verification
REQ-037 KEEP_WIDTH=8: beats tkeep=FF,FF,0F(last) -> record len=20, runt=1, oversize=0; status_valid the cycle after last.
REQ-038 Non-contiguous tkeep=A5 single-beat frame with tuser=1 -> len=4, err=1; next frame with tuser=0 -> err=0.
REQ-039 status_ready=0, FIFO_DEPTH=4, six 64-byte frames -> 4 records held, drop_count=2, frame_count=6; each record len=64, runt=0.
REQ-040 LEN_WIDTH=8, 40 full beats -> len=255, sat=1, oversize=1.
REQ-041 FIFO full with status_ready=1 and a tlast in the same cycle -> push accepted, drop_count unchanged.
REQ-042 rst asserted mid-frame after 3 beats, then a 2-beat full frame -> single record len=16; counters restart from 0.
